// File: rtl/nand_logic_pkg.sv
// Shared definitions for the NAND logic unit: op encodings, default sizes and buffer states.
package nand_logic_pkg;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefCntW  = 8;

    localparam logic [2:0] OP_IMP  = 3'd0;  // ~a | b
    localparam logic [2:0] OP_CIMP = 3'd1;  // a | ~b
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    // One-entry output buffer occupancy.
    typedef enum logic [0:0] {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/nand_bitwise_op.sv
// Gate-level bitwise logic: every function and the op-select mux are built from 2-input NANDs.
module nand_bitwise_op
    import nand_logic_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] y_o
);

    // Inverted select lines, shared by all bit slices.
    wire [2:0] op_n;

    for (genvar s = 0; s < 3; s++) begin : g_sel_inv
        nand u_inv (op_n[s], op_i[s], op_i[s]);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        wire na, nb, n_ab, and_r, imp_r, cimp_r, or_r, nor_r;
        wire t_a, t_b, xor_r, xnor_r;

        nand u_na   (na,     a_i[i], a_i[i]);
        nand u_nb   (nb,     b_i[i], b_i[i]);
        nand u_nab  (n_ab,   a_i[i], b_i[i]);
        nand u_and  (and_r,  n_ab,   n_ab);
        nand u_imp  (imp_r,  a_i[i], nb);
        nand u_cimp (cimp_r, b_i[i], na);
        nand u_or   (or_r,   na,     nb);
        nand u_nor  (nor_r,  or_r,   or_r);
        // Classic 4-NAND XOR, reusing n_ab as the first gate.
        nand u_xa   (t_a,    a_i[i], n_ab);
        nand u_xb   (t_b,    b_i[i], n_ab);
        nand u_xor  (xor_r,  t_a,    t_b);
        nand u_xnor (xnor_r, xor_r,  xor_r);

        // Op encodings pair up so op[0] picks within {IMP,CIMP},{NAND,AND},{OR,NOR},{XOR,XNOR}.
        wire [3:0] l1_d0, l1_d1, l1_p, l1_q, l1_y;
        wire [1:0] l2_p, l2_q, l2_y;
        wire       l3_p, l3_q;

        assign l1_d0 = {xor_r,  or_r,  n_ab,  imp_r};
        assign l1_d1 = {xnor_r, nor_r, and_r, cimp_r};

        for (genvar k = 0; k < 4; k++) begin : g_l1
            nand u_p (l1_p[k], l1_d1[k], op_i[0]);
            nand u_q (l1_q[k], l1_d0[k], op_n[0]);
            nand u_y (l1_y[k], l1_p[k],  l1_q[k]);
        end

        for (genvar k = 0; k < 2; k++) begin : g_l2
            nand u_p (l2_p[k], l1_y[2*k+1], op_i[1]);
            nand u_q (l2_q[k], l1_y[2*k],   op_n[1]);
            nand u_y (l2_y[k], l2_p[k],     l2_q[k]);
        end

        nand u_l3p (l3_p,   l2_y[1], op_i[2]);
        nand u_l3q (l3_q,   l2_y[0], op_n[2]);
        nand u_l3y (y_o[i], l3_p,    l3_q);
    end

endmodule

// File: rtl/nand_logic_unit.sv
// Self-checking logic stage: NAND-network and behavioural results captured into a one-entry
// valid/ready buffer, with a saturating count of accepted disagreements.
module nand_logic_unit
    import nand_logic_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             fault_inj,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_gate,
    output logic [WIDTH-1:0] s_expr,
    output logic             mismatch,
    input  logic             clear_err,
    output logic [CNT_W-1:0] err_count
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] s_gate_q, s_gate_d;
    logic [WIDTH-1:0] s_expr_q, s_expr_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] err_q, err_d;

    logic [WIDTH-1:0] gate_raw, gate_cap, expr_res;
    logic             accept, release_out;

    nand_bitwise_op #(
        .WIDTH (WIDTH)
    ) u_gate (
        .a_i  (a),
        .b_i  (b),
        .op_i (op),
        .y_o  (gate_raw)
    );

    assign out_valid   = (state_q == StFull);
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign release_out = out_valid && out_ready;

    // Fault hook flips gate bit 0 so the comparison and counter can be exercised.
    always_comb begin
        gate_cap    = gate_raw;
        gate_cap[0] = gate_raw[0] ^ fault_inj;
    end

    // Behavioural reference result.
    always_comb begin
        expr_res = '0;
        case (op)
            OP_IMP:  expr_res = ~a | b;
            OP_CIMP: expr_res = a | ~b;
            OP_NAND: expr_res = ~(a & b);
            OP_AND:  expr_res = a & b;
            OP_OR:   expr_res = a | b;
            OP_NOR:  expr_res = ~(a | b);
            OP_XOR:  expr_res = a ^ b;
            OP_XNOR: expr_res = ~(a ^ b);
            default: expr_res = '0;
        endcase
    end

    // Buffer next state and capture; an accept wins over a simultaneous release.
    always_comb begin
        state_d    = state_q;
        s_gate_d   = s_gate_q;
        s_expr_d   = s_expr_q;
        mismatch_d = mismatch_q;
        if (accept) begin
            state_d    = StFull;
            s_gate_d   = gate_cap;
            s_expr_d   = expr_res;
            mismatch_d = (gate_cap != expr_res);
        end else if (release_out) begin
            state_d = StEmpty;
        end
    end

    // Saturating error counter; clear overrides a same-cycle increment.
    always_comb begin
        err_d = err_q;
        if (clear_err) begin
            err_d = '0;
        end else if (accept && (gate_cap != expr_res) && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StEmpty;
            s_gate_q   <= '0;
            s_expr_q   <= '0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            s_gate_q   <= s_gate_d;
            s_expr_q   <= s_expr_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign s_gate    = s_gate_q;
    assign s_expr    = s_expr_q;
    assign mismatch  = mismatch_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_nand_logic_unit.sv
// Directed bench for nand_logic_unit at WIDTH=4, CNT_W=2.
module tb_nand_logic_unit;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b;
    logic [2:0]    op;
    logic          fault_inj;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s_gate, s_expr;
    logic          mismatch;
    logic          clear_err;
    logic [CW-1:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    nand_logic_unit #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .fault_inj (fault_inj),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_gate    (s_gate),
        .s_expr    (s_expr),
        .mismatch  (mismatch),
        .clear_err (clear_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference truth for the sweep.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [2:0] o);
        case (o)
            3'd0:    return ~x | y;
            3'd1:    return x | ~y;
            3'd2:    return ~(x & y);
            3'd3:    return x & y;
            3'd4:    return x | y;
            3'd5:    return ~(x | y);
            3'd6:    return x ^ y;
            default: return ~(x ^ y);
        endcase
    endfunction

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        fault_inj = 1'b0;
        out_ready = 1'b1;
        clear_err = 1'b0;
        tick();
        tick();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_s_gate", s_gate, 0);
        check_eq("rst_s_expr", s_expr, 0);
        check_eq("rst_mismatch", mismatch, 0);
        check_eq("rst_err", err_count, 0);
        check_eq("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // IMP first operation.
        in_valid = 1'b1;
        a = 4'b1100;
        b = 4'b1010;
        op = 3'd0;
        tick();
        check_eq("imp_valid", out_valid, 1);
        check_eq("imp_gate", s_gate, 4'b1011);
        check_eq("imp_expr", s_expr, 4'b1011);
        check_eq("imp_mm", mismatch, 0);

        op = 3'd6;
        tick();
        check_eq("xor_gate", s_gate, 4'b0110);
        check_eq("xor_expr", s_expr, 4'b0110);
        op = 3'd2;
        tick();
        check_eq("nand_gate", s_gate, 4'b0111);
        check_eq("nand_expr", s_expr, 4'b0111);
        op = 3'd1;
        tick();
        check_eq("cimp_gate", s_gate, 4'b1101);
        op = 3'd7;
        tick();
        check_eq("xnor_gate", s_gate, 4'b1001);

        // Full sweep, one op per cycle.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int io = 0; io < 8; io++) begin
                    a  = 4'(ia);
                    b  = 4'(ib);
                    op = 3'(io);
                    tick();
                    check_eq($sformatf("sw_gate a=%0h b=%0h op=%0d", ia, ib, io),
                             s_gate, ref_op(4'(ia), 4'(ib), 3'(io)));
                    check_eq($sformatf("sw_expr a=%0h b=%0h op=%0d", ia, ib, io),
                             s_expr, ref_op(4'(ia), 4'(ib), 3'(io)));
                    check_eq("sw_mm", mismatch, 0);
                end
            end
        end
        check_eq("sw_err", err_count, 0);

        // Backpressure.
        a = 4'b1100;
        b = 4'b1010;
        op = 3'd4;
        tick();
        check_eq("bp_first", s_gate, 4'b1110);
        out_ready = 1'b0;
        a = 4'b1111;
        b = 4'b1111;
        op = 3'd2;
        #1;
        check_eq("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_hold_valid", out_valid, 1);
            check_eq("bp_hold_gate", s_gate, 4'b1110);
            check_eq("bp_hold_expr", s_expr, 4'b1110);
            check_eq("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_ready_up", in_ready, 1);
        tick();
        check_eq("bp_new_valid", out_valid, 1);
        check_eq("bp_new_gate", s_gate, 4'b0000);
        check_eq("bp_new_expr", s_expr, 4'b0000);

        // Fault injection and saturation at 3.
        fault_inj = 1'b1;
        a = 4'b1111;
        b = 4'b0000;
        op = 3'd3;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("flt_mm", mismatch, 1);
            check_eq("flt_gate", s_gate, 4'b0001);
            check_eq("flt_expr", s_expr, 4'b0000);
            check_eq($sformatf("flt_err_%0d", i), err_count, (i > 3) ? 3 : i);
        end
        clear_err = 1'b1;
        tick();
        check_eq("clr_err", err_count, 0);
        check_eq("clr_mm", mismatch, 1);
        clear_err = 1'b0;
        fault_inj = 1'b0;
        tick();
        check_eq("post_clr_mm", mismatch, 0);
        check_eq("post_clr_err", err_count, 0);

        // Reset while full.
        out_ready = 1'b0;
        a = 4'b1100;
        b = 4'b1010;
        op = 3'd0;
        tick();
        check_eq("pre_rst_full", out_valid, 1);
        reset = 1'b1;
        tick();
        check_eq("mrst_valid", out_valid, 0);
        check_eq("mrst_gate", s_gate, 0);
        check_eq("mrst_expr", s_expr, 0);
        check_eq("mrst_mm", mismatch, 0);
        check_eq("mrst_err", err_count, 0);
        check_eq("mrst_ready", in_ready, 1);
        tick();
        check_eq("mrst_no_accept", out_valid, 0);
        reset = 1'b0;
        in_valid = 1'b0;
        tick();
        check_eq("idle_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
